gray_frame_capture: RTL

- Parametrised capture stage between the camera pixel stream and the grayscale frame buffer.
- Converts RGB565 pixels to GRAY_BITS-wide luma and generates raster write addresses.
- Gates buffer writes by capture mode: live, freeze, or single-shot.
- Mode changes apply only on frame boundaries, so the buffer never holds a torn frame.

---
 rtl/gray_frame_capture.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/gray_frame_capture.sv
// RGB565 -> luma capture stage with raster write addressing and frame-boundary mode gating.
// Define GRAY_MINMAX_EN to add per-frame luma min/max outputs (gray_min_out, gray_max_out).
module gray_frame_capture #(
    parameter int unsigned IMG_W     = 240,
    parameter int unsigned IMG_H     = 320,
    parameter int unsigned GRAY_BITS = 5,
    parameter int unsigned ADDR_W    = $clog2(IMG_W * IMG_H)
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic                 pixel_valid_in,
    input  logic [15:0]          pixel_in,
    input  logic                 frame_done_in,
    input  logic [1:0]           mode_in,
    input  logic                 capture_req_in,
    output logic                 wr_en_out,
    output logic [ADDR_W-1:0]    wr_addr_out,
    output logic [GRAY_BITS-1:0] wr_data_out,
    output logic                 busy_out,
    output logic                 capture_done_out,
    output logic                 overflow_out
`ifdef GRAY_MINMAX_EN
    ,
    output logic [GRAY_BITS-1:0] gray_min_out,
    output logic [GRAY_BITS-1:0] gray_max_out
`endif
);

    localparam int unsigned NumPix = IMG_W * IMG_H;
    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(NumPix - 1);

    typedef enum logic [1:0] {StSync, StLive, StHold, StCapture} state_e;

    state_e              state_q, state_d;
    logic                pending_q, pending_d;
    logic                capture_done_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                full_q, full_d;
    logic                overflow_d;
    logic                writing;
    logic                write_now;

    logic [7:0]          r8, g8, b8;
    logic                s1_valid_q;
    logic [ADDR_W-1:0]   s1_addr_q;
    logic [15:0]         prod_r_q, prod_g_q, prod_b_q;
    logic [15:0]         luma_sum;

    assign writing   = (state_q == StLive) || (state_q == StCapture);
    // full_q marks that the last address was already written this frame
    assign write_now = pixel_valid_in && writing && !full_q;
    assign busy_out  = writing;

    assign r8 = {pixel_in[15:11], pixel_in[15:13]};
    assign g8 = {pixel_in[10:5], pixel_in[10:9]};
    assign b8 = {pixel_in[4:0], pixel_in[4:2]};

    always_comb begin
        state_d        = state_q;
        pending_d      = pending_q;
        capture_done_d = 1'b0;
        if (capture_req_in && (mode_in == 2'b10) && (state_q != StCapture)) begin
            pending_d = 1'b1;
        end
        if (frame_done_in) begin
            case (state_q)
                StSync, StHold: begin
                    if (mode_in == 2'b00) begin
                        state_d = StLive;
                    end else if ((mode_in == 2'b10) && pending_q) begin
                        state_d = StCapture;
                    end else begin
                        state_d = StHold;
                    end
                end
                StLive: state_d = (mode_in == 2'b00) ? StLive : StHold;
                StCapture: begin
                    state_d        = StHold;
                    capture_done_d = 1'b1;
                    pending_d      = 1'b0;
                end
                default: state_d = StSync;
            endcase
        end
    end

    always_comb begin
        addr_d     = addr_q;
        full_d     = full_q;
        overflow_d = overflow_out;
        if (pixel_valid_in && writing) begin
            if (full_q) begin
                overflow_d = 1'b1;
            end else if (addr_q == LastAddr) begin
                full_d = 1'b1;
            end else begin
                addr_d = addr_q + 1'b1;
            end
        end
        if (frame_done_in) begin
            addr_d = '0;
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q          <= StSync;
            pending_q        <= 1'b0;
            capture_done_out <= 1'b0;
            addr_q           <= '0;
            full_q           <= 1'b0;
            overflow_out     <= 1'b0;
        end else begin
            state_q          <= state_d;
            pending_q        <= pending_d;
            capture_done_out <= capture_done_d;
            addr_q           <= addr_d;
            full_q           <= full_d;
            overflow_out     <= overflow_d;
        end
    end

    // Y[7:8-GRAY_BITS] is the top GRAY_BITS of the 16-bit weighted sum
    assign luma_sum = prod_r_q + prod_g_q + prod_b_q;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            s1_valid_q  <= 1'b0;
            s1_addr_q   <= '0;
            prod_r_q    <= '0;
            prod_g_q    <= '0;
            prod_b_q    <= '0;
            wr_en_out   <= 1'b0;
            wr_addr_out <= '0;
            wr_data_out <= '0;
        end else begin
            s1_valid_q  <= write_now;
            s1_addr_q   <= addr_q;
            prod_r_q    <= 16'd77 * {8'd0, r8};
            prod_g_q    <= 16'd150 * {8'd0, g8};
            prod_b_q    <= 16'd29 * {8'd0, b8};
            wr_en_out   <= s1_valid_q;
            wr_addr_out <= s1_addr_q;
            wr_data_out <= GRAY_BITS'(luma_sum >> (16 - GRAY_BITS));
        end
    end

`ifdef GRAY_MINMAX_EN
    logic [15:0]          cur_sum;
    logic [GRAY_BITS-1:0] cur_luma, min_now, max_now;
    logic [GRAY_BITS-1:0] run_min_q, run_max_q;
    logic                 seen_q;

    // Unpipelined luma so the pixel coinciding with frame_done_in is included
    assign cur_sum  = 16'd77 * {8'd0, r8} + 16'd150 * {8'd0, g8} + 16'd29 * {8'd0, b8};
    assign cur_luma = GRAY_BITS'(cur_sum >> (16 - GRAY_BITS));
    assign min_now  = (write_now && (cur_luma < run_min_q)) ? cur_luma : run_min_q;
    assign max_now  = (write_now && (cur_luma > run_max_q)) ? cur_luma : run_max_q;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            run_min_q    <= '1;
            run_max_q    <= '0;
            seen_q       <= 1'b0;
            gray_min_out <= '1;
            gray_max_out <= '0;
        end else if (frame_done_in) begin
            if (seen_q || write_now) begin
                gray_min_out <= min_now;
                gray_max_out <= max_now;
            end
            run_min_q <= '1;
            run_max_q <= '0;
            seen_q    <= 1'b0;
        end else begin
            run_min_q <= min_now;
            run_max_q <= max_now;
            seen_q    <= seen_q | write_now;
        end
    end
`endif

endmodule
